opcode_sequencer: RTL and testbench

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

---
 rtl/enclave_pkg.sv | 25 ++
 rtl/seq_timer.sv | 27 ++
 rtl/opcode_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_opcode_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enclave_pkg.sv
// Shared types and constants for the opcode sequencer.
package enclave_pkg;

  // Word counters are 8 bits wide and saturate instead of wrapping.
  localparam int CNT_W = 8;

  // Opcode value that cancels the command in flight (or clears err when idle).
  localparam logic [7:0] OPC_ABORT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } seq_state_e;

  // Saturating increment: termination is by equality compare, so a counter
  // must never wrap back through its terminal value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// RUN watchdog for the opcode sequencer. Counts enabled cycles from the
// clear point and raises expired once LIMIT-1 cycles have been counted
// after the first enabled cycle; holds there until cleared.
module seq_timer #(
  parameter int LIMIT = 1024
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // Cycle counter; stops at the limit so expired stays asserted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                 cnt_q <= '0;
    else if (clear)                 cnt_q <= '0;
    else if (enable && !expired)    cnt_q <= cnt_q + W'(1);
  end

  assign expired = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: collects an opcode and OPERAND_WORDS operands from the
// host, kicks the engine, then forwards RESULT_WORDS results back.
// Host write data arrives one cycle after its strobe, so strobes are
// registered and decoded against wishbone_data on the following cycle.
// Optional: define OPCODE_SEQ_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES
// cycles (counted from the eng_start cycle) without eng_done.
module opcode_sequencer
  import enclave_pkg::*;
#(
  parameter int OPERAND_WORDS  = 4,
  parameter int RESULT_WORDS   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        config_en,
  input  logic        input_ready,
  input  logic [31:0] wishbone_data,
  output logic [7:0]  eng_opcode,
  output logic        eng_start,
  output logic [31:0] eng_operand,
  output logic        eng_operand_valid,
  input  logic        eng_done,
  input  logic        eng_result_valid,
  input  logic [31:0] eng_result,
  output logic        output_ready,
  output logic [31:0] wishbone_output,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] OPD_LAST = CNT_W'(OPERAND_WORDS - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RESULT_WORDS - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
  logic             op_wr_q, opd_wr_q;
  logic             opc_ld, opd_fwd, res_fwd;
  logic             timeout_hit;
  logic [7:0]       opc_data;
  logic             opc_wr_busy, abort_busy, in_res;

  assign opc_data    = wishbone_data[7:0];
  // OPCODE is the sampling cycle of the write that left IDLE, so an opcode
  // write sampled there belongs to IDLE, not to a busy command.
  assign opc_wr_busy = op_wr_q && (state_q != ST_IDLE) && (state_q != ST_OPCODE);
  assign abort_busy  = opc_wr_busy && (opc_data == OPC_ABORT);
  assign in_res      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

`ifdef OPCODE_SEQ_TIMEOUT_EN
  logic tmr_expired;

  // Counting starts on the eng_start cycle so the abort lands exactly
  // TIMEOUT_CYCLES cycles after the start pulse.
  seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .enable    ((state_q == ST_START) || (state_q == ST_RUN)),
    .clear     ((state_q != ST_START) && (state_q != ST_RUN)),
    .expired   (tmr_expired)
  );

  assign timeout_hit = (state_q == ST_RUN) && tmr_expired;
`else
  // No watchdog: RUN waits for eng_done indefinitely (compare is never true).
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Register write strobes; config_en wins when both are raised.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_wr_q  <= 1'b0;
      opd_wr_q <= 1'b0;
    end else begin
      op_wr_q  <= config_en;
      opd_wr_q <= input_ready && !config_en;
    end
  end

  // Control state, word counter and sticky error.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

  // Next-state, counter and error decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err;
    opc_ld  = 1'b0;
    opd_fwd = 1'b0;
    res_fwd = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (config_en) state_d = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (opc_data == OPC_ABORT) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end else begin
          opc_ld  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (opd_wr_q) begin
          opd_fwd = 1'b1;
          cnt_d   = cnt_inc(cnt_q);
          if (cnt_q == OPD_LAST) state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        res_fwd = eng_result_valid;
        if (eng_done) begin
          // A result arriving with eng_done is word 0 of the drain.
          if (eng_result_valid && (RES_LAST == '0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = eng_result_valid ? CNT_W'(1) : '0;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (eng_result_valid) begin
          res_fwd = 1'b1;
          if (cnt_q == RES_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc(cnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (opd_wr_q && (state_q != ST_LOAD)) err_d = 1'b1;
    if (eng_result_valid && !in_res)      err_d = 1'b1;

    // Host opcode writes during a command: ABORT cancels it, anything else
    // is refused and flagged.
    if (opc_wr_busy) begin
      if (abort_busy) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = err;
        opd_fwd = 1'b0;
        res_fwd = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Registered datapath outputs toward the engine and the host.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      eng_opcode        <= '0;
      eng_operand       <= '0;
      eng_operand_valid <= 1'b0;
      wishbone_output   <= '0;
      output_ready      <= 1'b0;
    end else begin
      eng_operand_valid <= opd_fwd;
      output_ready      <= res_fwd;
      if (opc_ld)  eng_opcode      <= opc_data;
      if (opd_fwd) eng_operand     <= wishbone_data;
      if (res_fwd) wishbone_output <= eng_result;
    end
  end

  // An ABORT sampled in START suppresses the start pulse.
  assign eng_start = (state_q == ST_START) && !abort_busy;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_opcode_sequencer.sv
// Scoreboard bench for opcode_sequencer: stimulus pushes expected engine
// operands, start opcodes and host results; a negedge monitor pops them.
module tb_opcode_sequencer;

  localparam int OW = 4;
  localparam int RW = 4;
  localparam int TO = 1024;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        config_en = 1'b0;
  logic        input_ready = 1'b0;
  logic [31:0] wishbone_data = '0;
  logic        eng_done = 1'b0;
  logic        eng_result_valid = 1'b0;
  logic [31:0] eng_result = '0;
  logic [7:0]  eng_opcode;
  logic        eng_start;
  logic [31:0] eng_operand;
  logic        eng_operand_valid;
  logic        output_ready;
  logic [31:0] wishbone_output;
  logic        busy;
  logic        err;

  opcode_sequencer #(.OPERAND_WORDS(OW), .RESULT_WORDS(RW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .config_en(config_en),
    .input_ready(input_ready), .wishbone_data(wishbone_data),
    .eng_opcode(eng_opcode), .eng_start(eng_start), .eng_operand(eng_operand),
    .eng_operand_valid(eng_operand_valid), .eng_done(eng_done),
    .eng_result_valid(eng_result_valid), .eng_result(eng_result),
    .output_ready(output_ready), .wishbone_output(wishbone_output),
    .busy(busy), .err(err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] opd_q[$];
  logic [31:0] res_q[$];
  logic [7:0]  start_q[$];
  int n_starts = 0;
  int start_cyc = 0;
  bit err_m = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge wb_clk_i) begin
    if (wb_rst_ni) begin
      if (eng_operand_valid) begin
        if (opd_q.size() == 0) check("unexpected_operand_valid", eng_operand_valid, 1'b0);
        else                   check("eng_operand", eng_operand, opd_q.pop_front());
      end
      if (output_ready) begin
        if (res_q.size() == 0) check("unexpected_output_ready", output_ready, 1'b0);
        else                   check("wishbone_output", wishbone_output, res_q.pop_front());
      end
      if (eng_start) begin
        n_starts++;
        start_cyc = cyc;
        if (start_q.size() == 0) check("unexpected_eng_start", eng_start, 1'b0);
        else                     check("eng_opcode_at_start", {24'h0, eng_opcode}, {24'h0, start_q.pop_front()});
      end
    end
  end

  // One host write: strobe cycle (garbage data), then data cycle.
  task automatic wr(input bit opc, input logic [31:0] d);
    @(posedge wb_clk_i); #1;
    config_en     = opc;
    input_ready   = opc ? 1'($urandom_range(0, 1)) : 1'b1;
    wishbone_data = $urandom;
    @(posedge wb_clk_i); #1;
    config_en     = 1'b0;
    input_ready   = 1'b0;
    wishbone_data = d;
  endtask

  task automatic wr_opcode(input logic [7:0] opc);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = opc;
    wr(1'b1, d);
  endtask

  task automatic wait_start();
    int n0;
    n0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      if (n_starts != n0) break;
      @(posedge wb_clk_i);
    end
    check("eng_start_seen", 32'(n_starts - n0), 32'd1);
  endtask

  // Engine side: eng_done (optionally with result 0), then remaining results.
  task automatic finish_cmd(input bit coincide, input bit seq);
    logic [31:0] r;
    int k;
    k = 0;
    eng_done = 1'b1;
    if (coincide) begin
      r = seq ? 32'hB0 : $urandom;
      eng_result_valid = 1'b1;
      eng_result = r;
      res_q.push_back(r);
      k = 1;
    end
    @(posedge wb_clk_i); #1;
    eng_done = 1'b0;
    eng_result_valid = 1'b0;
    eng_result = $urandom;
    while (k < RW) begin
      repeat ($urandom_range(0, 2)) begin @(posedge wb_clk_i); #1; end
      r = seq ? 32'hB0 + 32'(k) : $urandom;
      eng_result_valid = 1'b1;
      eng_result = r;
      res_q.push_back(r);
      k++;
      @(posedge wb_clk_i); #1;
      eng_result_valid = 1'b0;
      eng_result = $urandom;
    end
    @(negedge wb_clk_i);
    check("busy_after_last_result", busy, 1'b0);
    check("err_after_cmd", err, err_m);
  endtask

  task automatic load_cmd(input logic [7:0] opc, input bit seq);
    logic [31:0] w;
    start_q.push_back(opc);
    wr_opcode(opc);
    for (int i = 0; i < OW; i++) begin
      w = seq ? 32'hA0 + 32'(i) : $urandom;
      opd_q.push_back(w);
      wr(1'b0, w);
    end
    wait_start();
    #1;
  endtask

  // inject: 1 = foreign opcode in RUN, 2 = stray operand in RUN, else none.
  task automatic run_cmd(input logic [7:0] opc, input int inject, input bit coincide, input bit seq);
    load_cmd(opc, seq);
    if (inject == 1) begin
      wr_opcode(8'($urandom_range(1, 255)));
      err_m = 1'b1;
    end else if (inject == 2) begin
      wr(1'b0, $urandom);
      err_m = 1'b1;
    end
    finish_cmd(coincide, seq);
  endtask

  task automatic abort_idle();
    wr_opcode(8'h00);
    err_m = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("busy_after_idle_abort", busy, 1'b0);
    check("err_after_idle_abort", err, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_eng_start"}, eng_start, 1'b0);
    check({tag, "_operand_valid"}, eng_operand_valid, 1'b0);
    check({tag, "_output_ready"}, output_ready, 1'b0);
    check({tag, "_eng_opcode"}, {24'h0, eng_opcode}, 32'h0);
    check({tag, "_eng_operand"}, eng_operand, 32'h0);
    check({tag, "_wishbone_output"}, wishbone_output, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    // Reset state
    #12;
    check_all_zero("reset");
    #11 wb_rst_ni = 1'b1;

    // Directed full command: opcode 0x12, operands A0..A3, results B0..B3
    run_cmd(8'h12, 0, 1'b0, 1'b1);

    // Abort mid-LOAD: no start, err untouched, IDLE the cycle after sampling
    wr_opcode(8'h12);
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      opd_q.push_back(w);
      wr(1'b0, w);
    end
    wr_opcode(8'h00);
    @(negedge wb_clk_i);
    check("busy_on_abort_sample", busy, 1'b1);
    @(negedge wb_clk_i);
    check("busy_after_abort", busy, 1'b0);
    check("err_after_abort", err, 1'b0);
    repeat (4) @(negedge wb_clk_i);

    // Foreign opcode during RUN, then ABORT in IDLE clears err
    run_cmd(8'h34, 1, 1'b0, 1'b0);
    check("err_sticky_after_foreign_opcode", err, 1'b1);
    abort_idle();

    // eng_done with coincident result: result counts as word 0
    run_cmd(8'h56, 0, 1'b1, 1'b1);

    // Result outside RUN/DRAIN is dropped and flags err
    @(posedge wb_clk_i); #1;
    eng_result_valid = 1'b1;
    eng_result = $urandom;
    @(posedge wb_clk_i); #1;
    eng_result_valid = 1'b0;
    err_m = 1'b1;
    @(negedge wb_clk_i);
    check("err_after_idle_result", err, 1'b1);
    abort_idle();

    // Randomized commands with occasional protocol violations
    for (int n = 0; n < 20; n++) begin
      int inj;
      inj = $urandom_range(0, 4);
      run_cmd(8'($urandom_range(1, 255)), inj, 1'($urandom_range(0, 1)), 1'b0);
      if (err_m && ($urandom_range(0, 1) == 1)) abort_idle();
    end
    if (err_m) abort_idle();

    // Asynchronous reset mid-LOAD
    wr_opcode(8'h33);
    for (int i = 0; i < 2; i++) begin
      w = $urandom | 32'h1;
      opd_q.push_back(w);
      wr(1'b0, w);
    end
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b0;
    #1 check_all_zero("async_reset");
    opd_q.delete();
    res_q.delete();
    start_q.delete();
    err_m = 1'b0;
    #14 wb_rst_ni = 1'b1;
    run_cmd(8'h77, 0, 1'b0, 1'b1);

    // RUN with eng_done withheld
    load_cmd(8'h21, 1'b0);
`ifdef OPCODE_SEQ_TIMEOUT_EN
    for (int i = 0; i < 1200; i++) begin
      @(negedge wb_clk_i);
      if (!busy) break;
    end
    check("timeout_busy", busy, 1'b0);
    check("timeout_cycles", 32'(cyc - start_cyc), 32'(TO));
    err_m = 1'b1;
    check("timeout_err", err, 1'b1);
    abort_idle();
`else
    repeat (1100) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("run_waits_busy", busy, 1'b1);
    @(posedge wb_clk_i); #1;
    finish_cmd(1'b0, 1'b0);
`endif

    repeat (5) @(negedge wb_clk_i);
    check("operand_queue_empty", 32'(opd_q.size()), 32'd0);
    check("result_queue_empty", 32'(res_q.size()), 32'd0);
    check("start_queue_empty", 32'(start_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
